// File: rtl/dsp_acc_pkg.sv
// Shared types and constants for the dual-lane product accumulator.
// Saturation limits here are consumed by dsp_requant when DSP_DUAL_ACC_SAT_EN is defined.
package dsp_acc_pkg;

  localparam int unsigned DEF_PROD_W = 16;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_OUT_W  = 8;

  typedef enum logic {S_IDLE, S_ACC} state_e;

  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint SAT_HI = sat_hi(DEF_OUT_W);
  localparam longint SAT_LO = sat_lo(DEF_OUT_W);

endpackage

// File: rtl/dsp_requant.sv
// Per-lane requantizer: floor arithmetic shift, then wrap or clamp to OUT_W bits.
// Clamping is selected by DSP_DUAL_ACC_SAT_EN; otherwise the result wraps.
module dsp_requant
  import dsp_acc_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] q
);

  logic signed [ACC_W-1:0] r;

  assign r = acc >>> SHIFT;

`ifdef DSP_DUAL_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] LimHi = ACC_W'(sat_hi(OUT_W));
  localparam logic signed [ACC_W-1:0] LimLo = ACC_W'(sat_lo(OUT_W));

  always_comb begin
    q = OUT_W'(r);
    if (r > LimHi) begin
      q = OUT_W'(LimHi);
    end else if (r < LimLo) begin
      q = OUT_W'(LimLo);
    end
  end
`else
  assign q = OUT_W'(r);
`endif

endmodule

// File: rtl/dsp_dual_acc.sv
// Dual-lane windowed accumulator with bias, requantization and a one-entry output buffer.
// Optional output clamping via DSP_DUAL_ACC_SAT_EN (evaluated in dsp_requant).
module dsp_dual_acc
  import dsp_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned LEN    = 9,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [PROD_W-1:0] in_ac,
  input  logic signed [PROD_W-1:0] in_bc,
  input  logic signed [ACC_W-1:0]  bias_a,
  input  logic signed [ACC_W-1:0]  bias_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_a,
  output logic signed [OUT_W-1:0]  out_b,
  output logic                     busy,
  output logic                     err_overrun
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [ACC_W-1:0] sext_a, sext_b, sum_a, sum_b;
  logic signed [OUT_W-1:0] rq_a, rq_b;
  logic signed [OUT_W-1:0] out_a_d, out_b_d;
  logic                    out_valid_d, err_d, busy_d;
  logic                    last_beat;

  // The first beat of a window replaces the accumulator with the bias.
  always_comb begin
    sext_a    = {{(ACC_W-PROD_W){in_ac[PROD_W-1]}}, in_ac};
    sext_b    = {{(ACC_W-PROD_W){in_bc[PROD_W-1]}}, in_bc};
    sum_a     = ((state_q == S_IDLE) ? bias_a : acc_a_q) + sext_a;
    sum_b     = ((state_q == S_IDLE) ? bias_b : acc_b_q) + sext_b;
    last_beat = in_valid && !clr && (state_q == S_ACC) && (count_q == CNT_W'(LEN - 1));
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    if (clr) begin
      state_d = S_IDLE;
      count_d = '0;
      acc_a_d = '0;
      acc_b_d = '0;
    end else if (in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ACC;
          count_d = CNT_W'(1);
          acc_a_d = sum_a;
          acc_b_d = sum_b;
        end
        S_ACC: begin
          if (last_beat) begin
            // The final sum goes straight to the requantizer, freeing the accumulators.
            state_d = S_IDLE;
            count_d = '0;
            acc_a_d = '0;
            acc_b_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
            acc_a_d = sum_a;
            acc_b_d = sum_b;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  dsp_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant_a (
    .acc (sum_a),
    .q   (rq_a)
  );

  dsp_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant_b (
    .acc (sum_b),
    .q   (rq_b)
  );

  // A completion can load only if the buffer is empty or is draining this cycle.
  always_comb begin
    out_valid_d = out_valid;
    out_a_d     = out_a;
    out_b_d     = out_b;
    err_d       = err_overrun;
    if (last_beat) begin
      if (!out_valid || out_ready) begin
        out_valid_d = 1'b1;
        out_a_d     = rq_a;
        out_b_d     = rq_b;
      end else begin
        err_d = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      out_valid   <= out_valid_d;
      out_a       <= out_a_d;
      out_b       <= out_b_d;
      busy        <= busy_d;
      err_overrun <= err_d;
    end
  end

endmodule

// File: doc/dsp_dual_acc.md
Name: dsp_dual_acc

Overview:
- Consumer-side partner of the dsp_dual_mult packed dual multiplier.
- Takes its two parallel signed product streams (ac, bc, qualified by valid_out) and accumulates LEN products per lane into dual dot-products.
- Adds a per-window bias, requantizes each sum to OUT_W bits, and presents the result pair on a valid/ready output with a one-entry buffer.
- Sits between the DSP multiplier array and the activation/writeback stage of the conv datapath.

Parameters:
- PROD_W, 16: width of incoming signed products.
- ACC_W, 32: signed accumulator width; must satisfy ACC_W >= PROD_W + clog2(LEN) + 1.
- LEN, 9: products per window (3x3 kernel). Must be >= 2.
- SHIFT, 4: arithmetic right shift applied at requantization.
- OUT_W, 8: signed output width per lane.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous soft clear of the current window.
- in_valid  in  1  product beat valid; driven from the multiplier's valid_out.
- in_ac  in  PROD_W  signed product, lane A.
- in_bc  in  PROD_W  signed product, lane B.
- bias_a  in  ACC_W  signed bias, lane A; sampled on the first beat of a window.
- bias_b  in  ACC_W  signed bias, lane B; sampled on the first beat of a window.
- out_valid  out  1  result pair available.
- out_ready  in  1  downstream accepts the result pair.
- out_a  out  OUT_W  requantized result, lane A.
- out_b  out  OUT_W  requantized result, lane B.
- busy  out  1  window in progress (beat count != 0).
- err_overrun  out  1  sticky: a completed window was dropped.

Behaviour:
- Reset (async, rst=1): count=0; acc_a=acc_b=0; out_valid=0; out_a=out_b=0; busy=0; err_overrun=0. Any in-flight window is discarded.
- There is no input backpressure. Every in_valid beat is consumed, except a beat that coincides with clr.
- FSM states:
  - S_IDLE (count==0).
  - S_ACC (1 <= count <= LEN-1).
  - Transitions: S_IDLE -> S_ACC on the first beat. S_ACC -> S_ACC while count < LEN-1. S_ACC -> S_IDLE on beat LEN.
- Beat handling:
  - First beat: acc <= bias + sext(in).
  - Subsequent beats: acc <= acc + sext(in).
  - Count increments only on in_valid. Gaps of any length between beats are allowed.
- Window completion (beat LEN at cycle t):
  - The requantized pair is written into the output buffer at t+1, with out_valid=1.
  - Results include beat LEN, via a combinational final add into the requantizer.
  - The accumulators are free for the next window's first beat at t+1 (back-to-back windows, zero bubble).
- Requantization, per lane:
  - r = acc_final >>> SHIFT (floor).
  - Reduce r to OUT_W bits: wrap or saturate, per the Optional Feature.
- Output buffer handshake:
  - out_valid, out_a and out_b stay stable until the cycle where out_valid && out_ready.
  - After that transfer, out_valid drops the next cycle unless a new result loads in the same cycle.
- Completion while the buffer is full:
  - If out_ready=1 in the same cycle: transfer and load the new result simultaneously; no error.
  - Otherwise: the new result is dropped, the buffer keeps the old pair, and err_overrun is set (cleared only by rst).
- clr:
  - Sets count=0 and acc=0, and discards an in_valid beat in the same cycle.
  - Does not touch the output buffer or err_overrun.
  - clr and rst together: rst dominates.
- busy = (count != 0), registered.

Optional Feature:
- Macro DSP_DUAL_ACC_SAT_EN.
- Defined: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: out = r[OUT_W-1:0] (two's-complement wrap).
- No other behaviour differs.

Decomposition:
- Package dsp_acc_pkg holds:
  - Default widths (PROD_W, ACC_W, OUT_W).
  - State typedef enum {S_IDLE, S_ACC}.
  - Constants for saturation limits derived from OUT_W.
- Sub-module dsp_requant (acc in, OUT_W out; shift + wrap/sat, combinational) is instantiated once per lane. The macro is evaluated only inside it.

Test Plan:
- Basic window: LEN=9, bias=0, 9 beats of in_ac=16, in_bc=-16, out_ready=1 -> one cycle after beat 9, out_valid=1, out_a=9, out_b=-9. out_valid is 0 the cycle after the transfer.
- Saturation: 9 beats of in_ac=32767, in_bc=-32768 -> with DSP_DUAL_ACC_SAT_EN, out_a=127, out_b=-128. Without it, out_a=-1 (0xFF), out_b=0 (0x00).
- Overrun: out_ready=0, 18 consecutive beats of in_ac=in_bc=16 -> out_a=9 held, second window dropped, err_overrun=1. Raising out_ready then gives exactly one transfer, and err_overrun stays 1.
- Clear and bias: 4 beats of 100, then clr, then 9 beats of in_ac=1 with bias_a=16 -> out_a=1 ((16+9)>>>4). clr together with in_valid counts no beat.
- Gaps and back-to-back: beats with random 0-5 cycle gaps across three windows, out_ready toggling randomly -> results match a reference model in order, with no extra or missing out_valid transfers.
- Async reset mid-window: assert rst between clock edges after beat 5 with out_valid=1 -> out_valid, out_a, out_b, busy and err_overrun go to 0 immediately. A following full window yields the correct result.
